// File: rtl/driver_motor_persiana.sv
// Motor driver behind the blind position FSM: turns subir/bajar level requests
// into motor enable/direction, with dead time, end-stop inhibit and run timeout.
module driver_motor_persiana #(
    parameter int DEAD_CYCLES    = 4,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int CNT_W          = 16
) (
    input  logic reloj,
    input  logic reset,
    input  logic subir,
    input  logic bajar,
    input  logic Ssup,
    input  logic Sinf,
    input  logic clr_fault,
    output logic motor_en,
    output logic motor_dir,
    output logic fault,
    output logic busy
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_UP    = 3'd1,
        S_DOWN  = 3'd2,
        S_DEAD  = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYCLES - 1);

    // Requests are levels held by the upstream FSM; there is no handshake, a
    // run lasts exactly as long as its request stays asserted and unopposed.
    state_t           state;
    logic [CNT_W-1:0] run_cnt;
    logic [CNT_W-1:0] dead_cnt;

    logic start_up;
    logic start_down;
    logic stop_up;
    logic stop_down;
    logic fault_ack;

    assign start_up   = subir & ~bajar & ~Ssup;
    assign start_down = bajar & ~subir & ~Sinf;
    assign stop_up    = ~subir | bajar | Ssup;
    assign stop_down  = ~bajar | subir | Sinf;
    assign fault_ack  = clr_fault & ~subir & ~bajar;

    always_ff @(posedge reloj or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            run_cnt   <= '0;
            dead_cnt  <= '0;
            motor_dir <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_up) begin
                        state     <= S_UP;
                        motor_dir <= 1'b1;
                        run_cnt   <= '0;
                    end else if (start_down) begin
                        state     <= S_DOWN;
                        motor_dir <= 1'b0;
                        run_cnt   <= '0;
                    end
                end
                S_UP: begin
                    // Stop wins over timeout when both fall on the same edge.
                    if (stop_up) begin
                        state    <= S_DEAD;
                        dead_cnt <= '0;
                    end else if (run_cnt == RUN_LAST) begin
                        state <= S_FAULT;
                    end else begin
                        run_cnt <= run_cnt + 1'b1;
                    end
                end
                S_DOWN: begin
                    if (stop_down) begin
                        state    <= S_DEAD;
                        dead_cnt <= '0;
                    end else if (run_cnt == RUN_LAST) begin
                        state <= S_FAULT;
                    end else begin
                        run_cnt <= run_cnt + 1'b1;
                    end
                end
                S_DEAD: begin
                    if (dead_cnt == DEAD_LAST) begin
                        state <= S_IDLE;
                    end else begin
                        dead_cnt <= dead_cnt + 1'b1;
                    end
                end
                S_FAULT: begin
                    // Leaving through DEAD keeps the off gap before any restart.
                    if (fault_ack) begin
                        state    <= S_DEAD;
                        dead_cnt <= '0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign motor_en = (state == S_UP) || (state == S_DOWN);
    assign fault    = (state == S_FAULT);
    assign busy     = (state != S_IDLE);

endmodule

// File: tb/tb_driver_motor_persiana.sv
// Directed bench for driver_motor_persiana: runs, reversal, inhibits, timeout,
// async reset and the stop-versus-timeout tie.
module tb_driver_motor_persiana;

    logic reloj = 1'b0;
    logic reset = 1'b1;
    logic subir = 1'b0, bajar = 1'b0, Ssup = 1'b0, Sinf = 1'b0, clr_fault = 1'b0;
    logic motor_en, motor_dir, fault, busy;

    logic subir_t = 1'b0, bajar_t = 1'b0, Ssup_t = 1'b0, Sinf_t = 1'b0, clr_t = 1'b0;
    logic en_t, dir_t, fault_t, busy_t;

    int n_checks = 0;
    int n_pass   = 0;
    logic [0:0] exp_q[$];

    driver_motor_persiana #(.DEAD_CYCLES(4), .TIMEOUT_CYCLES(20), .CNT_W(16)) dut (
        .reloj(reloj), .reset(reset), .subir(subir), .bajar(bajar),
        .Ssup(Ssup), .Sinf(Sinf), .clr_fault(clr_fault),
        .motor_en(motor_en), .motor_dir(motor_dir), .fault(fault), .busy(busy)
    );

    driver_motor_persiana #(.DEAD_CYCLES(4), .TIMEOUT_CYCLES(5), .CNT_W(16)) dut_t (
        .reloj(reloj), .reset(reset), .subir(subir_t), .bajar(bajar_t),
        .Ssup(Ssup_t), .Sinf(Sinf_t), .clr_fault(clr_t),
        .motor_en(en_t), .motor_dir(dir_t), .fault(fault_t), .busy(busy_t)
    );

    always #5 reloj = ~reloj;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic got, input logic exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    endtask

    task automatic tick();
        @(posedge reloj);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        // Reset state, checked while reset is held
        #1;
        check("rst_en", motor_en, 1'b0);
        check("rst_dir", motor_dir, 1'b0);
        check("rst_fault", fault, 1'b0);
        check("rst_busy", busy, 1'b0);
        ticks(2);
        reset = 1'b0;

        // Up run stopped by Ssup
        subir = 1'b1;
        tick();
        check("up_en", motor_en, 1'b1);
        check("up_dir", motor_dir, 1'b1);
        check("up_busy", busy, 1'b1);
        Ssup = 1'b1;
        tick();
        check("ssup_stop_en", motor_en, 1'b0);
        check("ssup_dead_busy", busy, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("dead_busy", busy, 1'b1);
            check("dead_en", motor_en, 1'b0);
        end
        tick();
        check("dead_done_busy", busy, 1'b0);
        tick();
        check("ssup_inhibit_en", motor_en, 1'b0);
        check("ssup_inhibit_busy", busy, 1'b0);
        check("dir_hold", motor_dir, 1'b1);
        subir = 1'b0;
        Ssup  = 1'b0;
        tick();

        // Reversal up -> down: motor off exactly 5 cycles
        subir = 1'b1;
        tick();
        check("rev_up_en", motor_en, 1'b1);
        ticks(3);
        subir = 1'b0;
        bajar = 1'b1;
        for (int i = 0; i < 5; i++) exp_q.push_back(1'b0);
        exp_q.push_back(1'b1);
        while (exp_q.size() > 0) begin
            tick();
            check("rev_gap_en", motor_en, exp_q.pop_front());
        end
        check("rev_dir", motor_dir, 1'b0);
        bajar = 1'b0;
        tick();
        check("down_stop_en", motor_en, 1'b0);
        ticks(4);
        check("down_idle_busy", busy, 1'b0);

        // Conflicting requests are ignored
        subir = 1'b1;
        bajar = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("conflict_en", motor_en, 1'b0);
            check("conflict_busy", busy, 1'b0);
        end
        subir = 1'b0;

        // Lowering into active bottom sensor refused
        Sinf = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("sinf_inhibit_en", motor_en, 1'b0);
            check("sinf_inhibit_busy", busy, 1'b0);
        end
        bajar = 1'b0;
        Sinf  = 1'b0;
        tick();

        // Timeout: motor high exactly 20 cycles, then fault
        subir = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("to_run_en", motor_en, 1'b1);
            check("to_run_fault", fault, 1'b0);
        end
        tick();
        check("to_fault", fault, 1'b1);
        check("to_fault_en", motor_en, 1'b0);
        check("to_fault_busy", busy, 1'b1);
        clr_fault = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("clr_blocked_fault", fault, 1'b1);
        end
        subir = 1'b0;
        tick();
        check("clr_fault_cleared", fault, 1'b0);
        check("clr_dead_busy", busy, 1'b1);
        check("clr_dead_en", motor_en, 1'b0);
        ticks(3);
        check("clr_dead_busy_end", busy, 1'b1);
        tick();
        check("clr_idle_busy", busy, 1'b0);
        check("clr_idle_fault", fault, 1'b0);
        clr_fault = 1'b0;

        // Async reset mid-DOWN, restart with no dead time
        bajar = 1'b1;
        tick();
        tick();
        check("ar_down_en", motor_en, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check("ar_en", motor_en, 1'b0);
        check("ar_dir", motor_dir, 1'b0);
        check("ar_busy", busy, 1'b0);
        check("ar_fault", fault, 1'b0);
        #2;
        reset = 1'b0;
        tick();
        check("ar_restart_en", motor_en, 1'b1);
        check("ar_restart_dir", motor_dir, 1'b0);
        bajar = 1'b0;
        tick();
        ticks(4);
        check("ar_end_busy", busy, 1'b0);

        // Stop versus timeout on the same edge, TIMEOUT_CYCLES=5
        subir_t = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("tie_run_en", en_t, 1'b1);
        end
        subir_t = 1'b0;
        tick();
        check("tie_stop_en", en_t, 1'b0);
        check("tie_fault", fault_t, 1'b0);
        check("tie_busy", busy_t, 1'b1);
        ticks(4);
        check("tie_idle_busy", busy_t, 1'b0);
        check("tie_idle_fault", fault_t, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/driver_motor_persiana.md
# driver_motor_persiana

- Downstream stage of the blind position FSM: consumes its `subir`/`bajar` requests and drives the blind motor.
- Protects the motor and end stops:
  - enforces a dead time between any stop and the next start, which covers direction reversal;
  - refuses motion into an active end-stop sensor;
  - latches a fault if a run exceeds a maximum duration.
- Moore FSM with two counters; all outputs are registered or decoded from state.

## Interface
Parameters:
- `DEAD_CYCLES`, default 4: motor-off cycles enforced after every run (valid range 1..2^CNT_W-1).
- `TIMEOUT_CYCLES`, default 1000: maximum cycles `motor_en` may stay high in one run (valid range 1..2^CNT_W-1).
- `CNT_W`, default 16: width of the run and dead-time counters.

Ports:
- `reloj` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `subir` in 1: raise request from the position FSM.
- `bajar` in 1: lower request from the position FSM.
- `Ssup` in 1: top end-stop sensor, active high.
- `Sinf` in 1: bottom end-stop sensor, active high.
- `clr_fault` in 1: fault acknowledge, level-sampled.
- `motor_en` out 1: motor power enable.
- `motor_dir` out 1: 1 = up, 0 = down.
- `fault` out 1: timeout fault latched.
- `busy` out 1: block not in IDLE.

## Operation
- States: IDLE, UP, DOWN, DEAD, FAULT. All transitions occur on the `reloj` rising edge.
- IDLE:
  - `subir & ~bajar & ~Ssup` -> UP; `motor_dir` set to 1, run counter cleared.
  - `bajar & ~subir & ~Sinf` -> DOWN; `motor_dir` set to 0, run counter cleared.
  - Otherwise stay in IDLE. This includes `subir=bajar=1` (conflict, ignored) and a request toward an end stop that is already active.
- UP:
  - Stop condition: `~subir | bajar | Ssup` -> DEAD.
  - Else, if run counter == TIMEOUT_CYCLES-1 -> FAULT.
  - Else run counter +1.
  - Stop takes priority over timeout on the same edge.
- DOWN: same as UP, with stop condition `~bajar | subir | Sinf`.
- DEAD:
  - Dead counter cleared on entry and incremented each cycle.
  - After DEAD_CYCLES cycles in DEAD -> IDLE.
  - All requests are ignored while in DEAD.
- FAULT:
  - Held until `clr_fault=1` and `subir=0` and `bajar=0` are sampled on the same edge; then -> DEAD.
  - `clr_fault` has no effect in any other state.
- Outputs:
  - `motor_en` = state is UP or DOWN.
  - `fault` = state is FAULT.
  - `busy` = state is not IDLE.
  - `motor_dir` is a register updated only on entry to UP/DOWN; it holds its value in all other states.
- Counters saturate-free: neither counter can exceed its limit under the transitions above. The run counter is used only in UP/DOWN; the dead counter only in DEAD.

## Timing
- Reset (async, immediate): state IDLE, both counters 0, `motor_en=0`, `motor_dir=0`, `fault=0`, `busy=0`.
- A reset asserted mid-run drops `motor_en` without waiting for a clock edge. No dead time is applied after reset release.
- Start latency: request sampled at edge N -> `motor_en=1` and `motor_dir` valid from edge N.
- Stop latency: stop condition sampled at edge M -> `motor_en=0` from edge M.
- Minimum off gap between any two runs: DEAD_CYCLES+1 cycles, because DEAD occupies DEAD_CYCLES cycles and IDLE samples for one more.
- Timeout: a run entered at edge N with no stop condition goes to FAULT at edge N+TIMEOUT_CYCLES, so `motor_en` is high for exactly TIMEOUT_CYCLES cycles.
- Reversal: `subir` 1->0 and `bajar` 0->1 on the same cycle -> UP->DEAD at that edge; DOWN is entered no earlier than DEAD_CYCLES+1 edges later.
- An end-stop sensor rising on the very edge of entry is acted on at the next edge, so the run lasts one cycle.

## Test plan
- Up run: reset; `subir=1` -> `motor_en=1`, `motor_dir=1` at the next edge. `Ssup=1` -> `motor_en=0` next edge, `busy=1` for 4 cycles, then IDLE.
- Reversal: running UP, switch to `bajar=1`, `subir=0` -> `motor_en` low for exactly 5 cycles, then `motor_en=1` with `motor_dir=0`.
- Inhibits:
  - `subir=bajar=1` in IDLE for 10 cycles -> `motor_en=0`, `busy=0` throughout.
  - `bajar=1` with `Sinf=1` -> no motion.
- Timeout with TIMEOUT_CYCLES=20, holding `subir=1`, `Ssup=0`:
  - `motor_en` high exactly 20 cycles, then `fault=1`.
  - `clr_fault=1` while `subir=1` -> still FAULT.
  - `subir=0` with `clr_fault=1` -> DEAD for 4 cycles -> IDLE, `fault=0`.
- Async reset mid-DOWN: all outputs go to 0 before the next edge. After release, `bajar` held -> `motor_en=1` at the first edge.
- Stop-vs-timeout tie, TIMEOUT_CYCLES=5: drop `subir` on the cycle the run counter reaches 4 -> DEAD entered, `fault` stays 0.
